// File: rtl/hazard_ctrl_sb_if.sv
// Handshake bundle between the pipeline control logic and the scoreboard hazard controller.
interface hazard_ctrl_sb_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             mem_req;
    logic             dhit;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_wen;
    logic             id_load;
    logic             id_jump;
    logic             ex_jr;
    logic             id_halt;
    logic             br_taken;
    logic [3:0]       en;
    logic [3:0]       flush;
    logic             pc_en;
    logic             iren;
    logic             halt;
    logic             hz_stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ihit, mem_req, dhit, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_wen, id_load, id_jump, ex_jr, id_halt, br_taken,
        input  en, flush, pc_en, iren, halt, hz_stall, stall_cnt
    );

    modport slave (
        input  ihit, mem_req, dhit, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_wen, id_load, id_jump, ex_jr, id_halt, br_taken,
        output en, flush, pc_en, iren, halt, hz_stall, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_sb.sv
// Scoreboard hazard controller: per-register pending-write counters, EX/MEM destination
// shadows, draining halt FSM and a saturating data-hazard stall counter.
module hazard_ctrl_sb #(
    parameter int NREGS        = 32,
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter int ALU_LAT      = 0,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic            CLK,
    input  logic            RST,
    hazard_ctrl_sb_if.slave hz
);
    localparam int MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
    localparam int PEND_W  = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
    localparam int DRN_W   = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t            state, state_nxt;
    logic [PEND_W-1:0] pend [NREGS];
    logic [DRN_W-1:0]  drain_cnt;
    logic [REG_W-1:0]  dst_p1, dst_p2;
    logic              vld_p1, vld_p2;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic [3:0] en_c, flush_c;
    logic       pc_en_c, iren_c, hz_stall_c;
    logic       frozen, br_act, hazard, issue;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic is_pend(input logic [REG_W-1:0] r);
        logic p;
        p = 1'b0;
        for (int i = 1; i < NREGS; i++)
            if (r == REG_W'(i) && pend[i] != '0) p = 1'b1;
        return p;
    endfunction

    always_comb begin
        en_c       = 4'b1111;
        flush_c    = 4'b0000;
        pc_en_c    = 1'b1;
        iren_c     = 1'b1;
        hz_stall_c = 1'b0;
        frozen     = 1'b0;
        state_nxt  = state;
        br_act     = hz.br_taken && (state != HALTED);
        hazard     = hz.id_valid && ((hz.id_use_rs && is_pend(hz.id_rs)) ||
                                     (hz.id_use_rt && is_pend(hz.id_rt)));
        if (state == HALTED) begin
            en_c    = 4'b0000;
            pc_en_c = 1'b0;
            iren_c  = 1'b0;
        end else if (hz.br_taken) begin
            flush_c   = 4'b0111;
            state_nxt = RUN;
        end else if (hz.mem_req && !hz.dhit) begin
            // Freeze leaves every latch holding; a flush here would drop the ID/EX contents.
            frozen  = 1'b1;
            en_c    = 4'b0000;
            pc_en_c = 1'b0;
            iren_c  = (state != DRAIN);
        end else if (state == DRAIN) begin
            en_c[0]    = 1'b0;
            flush_c[1] = 1'b1;
            pc_en_c    = 1'b0;
            iren_c     = 1'b0;
            if (drain_cnt <= DRN_W'(1)) state_nxt = HALTED;
        end else if (hz.ex_jr) begin
            flush_c = 4'b0011;
        end else if (hazard) begin
            en_c[0]    = 1'b0;
            flush_c[1] = 1'b1;
            pc_en_c    = 1'b0;
            hz_stall_c = 1'b1;
        end else if (hz.id_jump) begin
            flush_c[0] = 1'b1;
        end else if (hz.id_halt) begin
            en_c[0]    = 1'b0;
            flush_c[1] = 1'b1;
            pc_en_c    = 1'b0;
            iren_c     = 1'b0;
            state_nxt  = DRAIN;
        end else if (!hz.ihit) begin
            pc_en_c    = 1'b0;
            flush_c[0] = 1'b1;
        end
        issue = en_c[1] && !flush_c[1] && hz.id_valid && hz.id_wen && (hz.id_dst != '0);
    end

    assign hz.en        = en_c;
    assign hz.flush     = flush_c;
    assign hz.pc_en     = pc_en_c;
    assign hz.iren      = iren_c;
    assign hz.hz_stall  = hz_stall_c;
    assign hz.halt      = (state == HALTED);
    assign hz.stall_cnt = stall_cnt_q;

    // Control state: FSM, scoreboard, shadow valids, stall counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NREGS; i++) pend[i] <= '0;
        end else begin
            state <= state_nxt;
            if (hz_stall_c) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (!frozen) begin
                vld_p1 <= issue && !br_act;
                vld_p2 <= vld_p1 && !br_act;
                for (int i = 0; i < NREGS; i++) begin
                    if (issue && hz.id_dst == REG_W'(i))
                        pend[i] <= hz.id_load ? PEND_W'(LOAD_LAT) : PEND_W'(ALU_LAT);
                    else if (br_act && ((vld_p1 && dst_p1 == REG_W'(i)) ||
                                        (vld_p2 && dst_p2 == REG_W'(i))))
                        pend[i] <= '0;
                    else if (pend[i] != '0)
                        pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

    // Drain counter is always loaded on entry to DRAIN, so it needs no reset
    always_ff @(posedge CLK) begin
        if (state == RUN && state_nxt == DRAIN)
            drain_cnt <= DRN_W'(DRAIN_CYCLES);
        else if (state == DRAIN && !frozen && drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;
    end

    // EX/MEM destination shadows (data only)
    always_ff @(posedge CLK) begin
        if (!frozen) begin
            dst_p1 <= hz.id_dst;
            dst_p2 <= dst_p1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Randomized and directed bench for hazard_ctrl_sb against a time-stamp based reference model.
module tb_hazard_ctrl_sb;
    localparam int LL = 1, AL = 2, DC = 3, CW = 4;

    typedef struct packed {
        logic       rst, ihit, mem_req, dhit, valid;
        logic [4:0] rs, rt;
        logic       use_rs, use_rt;
        logic [4:0] dst;
        logic       wen, load, jump, jr, halt, br;
    } stim_t;

    typedef struct packed {
        logic [3:0]    en, flush;
        logic          pc_en, iren, halt, hz;
        logic [CW-1:0] cnt;
    } obs_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    hazard_ctrl_sb_if #(.REG_W(5), .CNT_W(CW)) hif ();
    hazard_ctrl_sb #(.NREGS(32), .REG_W(5), .LOAD_LAT(LL), .ALU_LAT(AL),
                     .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .hz(hif));

    always #5 CLK = ~CLK;

    // Reference model: a register is busy until the advancing-cycle time stored in avail[].
    int tnow, stalls, halt_time;
    bit draining;
    int avail [32];
    int iss [int];

    function automatic void model_reset();
        tnow = 0; stalls = 0; halt_time = 0; draining = 0;
        foreach (avail[r]) avail[r] = 0;
        iss.delete();
    endfunction

    function automatic obs_t model_out(input stim_t s);
        obs_t o;
        bit halted, haz;
        halted = draining && (tnow >= halt_time);
        haz = s.valid && ((s.use_rs && tnow < avail[s.rs]) || (s.use_rt && tnow < avail[s.rt]));
        o.en = 4'hF; o.flush = 4'h0; o.pc_en = 1'b1; o.iren = 1'b1; o.halt = halted; o.hz = 1'b0;
        o.cnt = CW'((stalls >= (1 << CW) - 1) ? (1 << CW) - 1 : stalls);
        if (halted) begin o.en = 4'h0; o.pc_en = 1'b0; o.iren = 1'b0; end
        else if (s.br) o.flush = 4'b0111;
        else if (s.mem_req && !s.dhit) begin o.en = 4'h0; o.pc_en = 1'b0; o.iren = !draining; end
        else if (draining) begin o.en = 4'b1110; o.flush = 4'b0010; o.pc_en = 1'b0; o.iren = 1'b0; end
        else if (s.jr) o.flush = 4'b0011;
        else if (haz) begin o.en = 4'b1110; o.flush = 4'b0010; o.pc_en = 1'b0; o.hz = 1'b1; end
        else if (s.jump) o.flush = 4'b0001;
        else if (s.halt) begin o.en = 4'b1110; o.flush = 4'b0010; o.pc_en = 1'b0; o.iren = 1'b0; end
        else if (!s.ihit) begin o.pc_en = 1'b0; o.flush = 4'b0001; end
        return o;
    endfunction

    function automatic void model_adv(input stim_t s);
        obs_t o;
        bit halted;
        if (s.rst) begin model_reset(); return; end
        o = model_out(s);
        halted = draining && (tnow >= halt_time);
        if (o.hz) stalls++;
        if (!halted && !s.br && s.mem_req && !s.dhit) return;
        if (s.br && !halted) begin
            for (int k = 1; k <= 2; k++) if (iss.exists(tnow - k)) avail[iss[tnow - k]] = 0;
            iss.delete();
            draining = 0;
        end
        if (o.en[1] && !o.flush[1] && s.valid && s.wen && s.dst != 0) begin
            avail[s.dst] = tnow + 1 + (s.load ? LL : AL);
            iss[tnow] = s.dst;
        end
        if (!draining && !s.br && !s.jr && !o.hz && !s.jump && s.halt) begin
            draining = 1;
            halt_time = tnow + 1 + DC;
        end
        if (iss.exists(tnow - 3)) iss.delete(tnow - 3);
        tnow++;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0; s.ihit = 1'b1; s.dhit = 1'b1;
        return s;
    endfunction

    function automatic stim_t op(input int rs, input int rt, input bit urs, input bit urt,
                                 input int dst, input bit ld);
        stim_t s;
        s = idle(); s.valid = 1'b1; s.rs = 5'(rs); s.rt = 5'(rt); s.use_rs = urs; s.use_rt = urt;
        s.dst = 5'(dst); s.wen = 1'b1; s.load = ld;
        return s;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.en = hif.en; o.flush = hif.flush; o.pc_en = hif.pc_en; o.iren = hif.iren;
        o.halt = hif.halt; o.hz = hif.hz_stall; o.cnt = hif.stall_cnt;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        @(negedge CLK);
        RST = s.rst; hif.ihit = s.ihit; hif.mem_req = s.mem_req; hif.dhit = s.dhit;
        hif.id_valid = s.valid; hif.id_rs = s.rs; hif.id_rt = s.rt; hif.id_use_rs = s.use_rs;
        hif.id_use_rt = s.use_rt; hif.id_dst = s.dst; hif.id_wen = s.wen; hif.id_load = s.load;
        hif.id_jump = s.jump; hif.ex_jr = s.jr; hif.id_halt = s.halt; hif.br_taken = s.br;
        #1;
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle(); s.rst = 1'b1;
        apply(s); model_adv(s);
    endtask

    task automatic test_reset();
        stim_t s; obs_t got, exp;
        do_reset();
        s = idle();
        apply(s); got = observed(); exp = model_out(s);
        n_chk++; if (got !== exp) begin n_fail++; $display("FAIL reset_model: got %h expected %h", got, exp); end
        n_chk++;
        if (hif.en !== 4'hF || hif.flush !== 4'h0 || hif.pc_en !== 1'b1 || hif.iren !== 1'b1 ||
            hif.halt !== 1'b0 || hif.hz_stall !== 1'b0 || hif.stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: en=%h flush=%h pc_en=%b iren=%b halt=%b hz=%b cnt=%0d, expected F 0 1 1 0 0 0",
                     hif.en, hif.flush, hif.pc_en, hif.iren, hif.halt, hif.hz_stall, hif.stall_cnt);
        end
        model_adv(s);
    endtask

    task automatic test_load_use();
        stim_t seq[4]; obs_t got, exp;
        do_reset();
        seq = '{op(0, 0, 0, 0, 5, 1), op(5, 1, 1, 1, 6, 0), op(5, 1, 1, 1, 6, 0), idle()};
        foreach (seq[i]) begin
            apply(seq[i]); got = observed(); exp = model_out(seq[i]);
            n_chk++; if (got !== exp) begin n_fail++; $display("FAIL load_use[%0d]: got %h expected %h", i, got, exp); end
            if (i == 1) begin
                n_chk++;
                if (hif.hz_stall !== 1'b1 || hif.flush !== 4'b0010 || hif.pc_en !== 1'b0) begin
                    n_fail++; $display("FAIL load_use_stall: hz=%b flush=%b pc_en=%b, expected 1 0010 0", hif.hz_stall, hif.flush, hif.pc_en);
                end
            end
            if (i == 2) begin
                n_chk++;
                if (hif.hz_stall !== 1'b0 || hif.stall_cnt !== 4'd1) begin
                    n_fail++; $display("FAIL load_use_release: hz=%b cnt=%0d, expected 0 1", hif.hz_stall, hif.stall_cnt);
                end
            end
            model_adv(seq[i]);
        end
    endtask

    task automatic test_freeze_stall();
        stim_t seq[7]; obs_t got, exp;
        do_reset();
        foreach (seq[i]) seq[i] = op(5, 1, 1, 1, 6, 0);
        seq[0] = op(0, 0, 0, 0, 5, 1);
        for (int i = 1; i <= 3; i++) begin seq[i].mem_req = 1'b1; seq[i].dhit = 1'b0; end
        seq[6] = idle();
        foreach (seq[i]) begin
            apply(seq[i]); got = observed(); exp = model_out(seq[i]);
            n_chk++; if (got !== exp) begin n_fail++; $display("FAIL freeze[%0d]: got %h expected %h", i, got, exp); end
            if (i >= 1 && i <= 3) begin
                n_chk++;
                if (hif.en !== 4'h0 || hif.hz_stall !== 1'b0) begin
                    n_fail++; $display("FAIL freeze_hold[%0d]: en=%h hz=%b, expected 0 0", i, hif.en, hif.hz_stall);
                end
            end
            if (i == 4 || i == 5) begin
                n_chk++;
                if (hif.hz_stall !== (i == 4) || hif.stall_cnt !== 4'(i - 4)) begin
                    n_fail++; $display("FAIL freeze_stall[%0d]: hz=%b cnt=%0d, expected %0d %0d", i, hif.hz_stall, hif.stall_cnt, i == 4, i - 4);
                end
            end
            model_adv(seq[i]);
        end
    endtask

    task automatic test_alu_lat();
        stim_t seq[5]; obs_t got, exp;
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 3 : 0;
            do_reset();
            seq = '{op(0, 0, 0, 0, d, 0), op(d, d, 1, 1, 4, 0), op(d, d, 1, 1, 4, 0), op(d, d, 1, 1, 4, 0), idle()};
            foreach (seq[i]) begin
                apply(seq[i]); got = observed(); exp = model_out(seq[i]);
                n_chk++; if (got !== exp) begin n_fail++; $display("FAIL alu_lat%0d[%0d]: got %h expected %h", k, i, got, exp); end
                if (i >= 1 && i <= 3) begin
                    n_chk++;
                    if (hif.hz_stall !== (k == 0 && i <= 2)) begin
                        n_fail++; $display("FAIL alu_stall%0d[%0d]: hz=%b, expected %0d", k, i, hif.hz_stall, k == 0 && i <= 2);
                    end
                end
                if (i == 4) begin
                    n_chk++;
                    if (hif.stall_cnt !== ((k == 0) ? 4'd2 : 4'd0)) begin
                        n_fail++; $display("FAIL alu_count%0d: cnt=%0d, expected %0d", k, hif.stall_cnt, (k == 0) ? 2 : 0);
                    end
                end
                model_adv(seq[i]);
            end
        end
    endtask

    task automatic test_branch_shadow();
        stim_t seq[4]; obs_t got, exp;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            seq = '{op(0, 0, 0, 0, 7, k[0]), idle(), op(7, 7, 1, 1, 8, 0), idle()};
            seq[1].br = 1'b1;
            foreach (seq[i]) begin
                apply(seq[i]); got = observed(); exp = model_out(seq[i]);
                n_chk++; if (got !== exp) begin n_fail++; $display("FAIL branch%0d[%0d]: got %h expected %h", k, i, got, exp); end
                if (i == 1) begin
                    n_chk++;
                    if (hif.flush !== 4'b0111) begin n_fail++; $display("FAIL branch_flush%0d: flush=%b, expected 0111", k, hif.flush); end
                end
                if (i == 2) begin
                    n_chk++;
                    if (hif.hz_stall !== 1'b0) begin n_fail++; $display("FAIL branch_clear%0d: hz=%b, expected 0", k, hif.hz_stall); end
                end
                model_adv(seq[i]);
            end
        end
    endtask

    task automatic test_halt_drain();
        stim_t seq[6]; obs_t got, exp;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            foreach (seq[i]) seq[i] = idle();
            seq[0].halt = 1'b1;
            if (k == 1) seq[1].br = 1'b1;
            if (k == 2) seq[2].rst = 1'b1;
            foreach (seq[i]) begin
                apply(seq[i]); got = observed(); exp = model_out(seq[i]);
                n_chk++; if (got !== exp) begin n_fail++; $display("FAIL halt%0d[%0d]: got %h expected %h", k, i, got, exp); end
                if (k == 0 && i == 0) begin
                    n_chk++;
                    if (hif.iren !== 1'b0) begin n_fail++; $display("FAIL halt_iren: iren=%b, expected 0", hif.iren); end
                end
                if (k == 0 && (i == 3 || i == 4)) begin
                    n_chk++;
                    if (hif.halt !== (i == 4)) begin n_fail++; $display("FAIL halt_edge[%0d]: halt=%b, expected %0d", i, hif.halt, i == 4); end
                end
                if (k != 0 && i == 5) begin
                    n_chk++;
                    if (hif.iren !== 1'b1 || hif.halt !== 1'b0) begin
                        n_fail++; $display("FAIL halt_cancel%0d: iren=%b halt=%b, expected 1 0", k, hif.iren, hif.halt);
                    end
                end
                model_adv(seq[i]);
            end
        end
    endtask

    task automatic test_saturate();
        stim_t s; obs_t got, exp;
        do_reset();
        s = op(3, 3, 1, 0, 3, 0);
        for (int i = 0; i < 30; i++) begin
            apply(s); got = observed(); exp = model_out(s);
            n_chk++; if (got !== exp) begin n_fail++; $display("FAIL saturate[%0d]: got %h expected %h", i, got, exp); end
            model_adv(s);
        end
        s = idle(); s.halt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply(s); got = observed(); exp = model_out(s);
            n_chk++; if (got !== exp) begin n_fail++; $display("FAIL sat_halt[%0d]: got %h expected %h", i, got, exp); end
            model_adv(s);
            s.halt = 1'b0;
        end
        n_chk++;
        if (hif.stall_cnt !== 4'd15 || hif.halt !== 1'b1) begin
            n_fail++; $display("FAIL sat_value: cnt=%0d halt=%b, expected 15 1", hif.stall_cnt, hif.halt);
        end
        do_reset();
        s = idle();
        apply(s);
        n_chk++;
        if (hif.stall_cnt !== 4'd0 || hif.halt !== 1'b0) begin
            n_fail++; $display("FAIL sat_reset: cnt=%0d halt=%b, expected 0 0", hif.stall_cnt, hif.halt);
        end
        model_adv(s);
    endtask

    task automatic test_random();
        stim_t s; obs_t got, exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst     = ($urandom_range(99) == 0);
            s.ihit    = ($urandom_range(7) != 0);
            s.mem_req = ($urandom_range(3) == 0);
            s.dhit    = 1'($urandom_range(1));
            s.valid   = ($urandom_range(3) != 0);
            s.rs      = 5'($urandom_range(7));
            s.rt      = 5'($urandom_range(7));
            s.use_rs  = 1'($urandom_range(1));
            s.use_rt  = 1'($urandom_range(1));
            s.dst     = 5'($urandom_range(7));
            s.wen     = 1'($urandom_range(1));
            s.load    = 1'($urandom_range(1));
            s.jump    = ($urandom_range(9) == 0);
            s.jr      = ($urandom_range(11) == 0);
            s.halt    = ($urandom_range(39) == 0);
            s.br      = ($urandom_range(11) == 0);
            apply(s); got = observed(); exp = model_out(s);
            n_chk++; if (got !== exp) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp); end
            model_adv(s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_freeze_stall();
        test_alu_lat();
        test_branch_shadow();
        test_halt_drain();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_sb.md
# hazard_ctrl_sb

Parametrised scoreboard-based hazard controller for the pipelined datapath. It sits beside the control unit and the four pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB. It produces per-latch enable and flush vectors, PC enable and instruction-read enable. Compared with a purely combinational hazard unit it adds:
- a per-register pending-write scoreboard with configurable load and ALU latency;
- a draining halt state machine that can be cancelled;
- a saturating stall-cycle counter.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; register 0 is never pending.
- REG_W, 5, register index width; NREGS <= 2**REG_W.
- LOAD_LAT, 1, bubbles required between a load and a dependent instruction.
- ALU_LAT, 0, bubbles required after a non-load writer; set 2 for no-forwarding builds.
- DRAIN_CYCLES, 3, advancing cycles needed to retire instructions older than halt.
- CNT_W, 32, stall counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  instruction memory hit this cycle.
- mem_req  in  1  MEM-stage data read or write is pending.
- dhit  in  1  data memory hit.
- id_valid  in  1  ID latch holds a real instruction.
- id_rs, id_rt  in  REG_W  source register indices at ID.
- id_use_rs, id_use_rt  in  1  source is actually read.
- id_dst  in  REG_W  destination register at ID.
- id_wen  in  1  instruction at ID writes id_dst.
- id_load  in  1  instruction at ID is a load.
- id_jump  in  1  J/JAL decoded at ID.
- ex_jr  in  1  JR resolved in EX.
- id_halt  in  1  halt decoded at ID.
- br_taken  in  1  branch resolved taken in MEM.
- en  out  4  latch enables; bit 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB.
- flush  out  4  latch flushes, same indexing; flush wins over hold at the latch.
- pc_en  out  1  PC update enable.
- iren  out  1  instruction read enable.
- halt  out  1  processor halted; sticky.
- hz_stall  out  1  data-hazard stall active this cycle.
- stall_cnt  out  CNT_W  saturating count of hz_stall cycles.

## Operation
- Default outputs, when no condition below applies: en=4'b1111, flush=0, pc_en=1, iren=1, hz_stall=0.
- Priority order; the first matching condition applies:
  1. State HALTED: en=0, flush=0, pc_en=0, iren=0, halt=1.
  2. br_taken: flush=4'b0111.
     - Scoreboard entries of the destinations shadowed in EX and MEM are zeroed.
     - If the state is DRAIN, the next state is RUN.
  3. mem_req && !dhit (freeze): en=0, pc_en=0. Scoreboard, drain counter and shadows hold.
  4. ex_jr: flush=4'b0011.
  5. Data hazard: id_valid && ((id_use_rs && pend[id_rs]!=0) || (id_use_rt && pend[id_rt]!=0)).
     - Outputs: pc_en=0, en[0]=0, flush[1]=1, hz_stall=1.
     - This overrides id_jump and id_halt; they are re-evaluated once the stall clears.
  6. id_jump: flush[0]=1.
  7. id_halt in RUN: pc_en=0, iren=0, en[0]=0, flush[1]=1; next state is DRAIN.
  8. !ihit: pc_en=0, flush[0]=1.
- Scoreboard: one counter pend[r] per register, width clog2(max(LOAD_LAT,ALU_LAT)+1).
  - An issue happens in a cycle where en[1]=1, flush[1]=0, id_valid=1, id_wen=1 and id_dst!=0.
  - On issue, pend[id_dst] is loaded with LOAD_LAT if id_load, otherwise ALU_LAT.
  - Every other nonzero entry decrements by 1 in each cycle that is not frozen.
  - When an issue and a decrement hit the same register, the issue load wins.
- Shadows: a dst+valid pair for EX and one for MEM.
  - They shift each non-frozen cycle: the EX shadow takes the issue, the MEM shadow takes the old EX shadow.
  - Both are cleared on br_taken.
- Halt FSM with states RUN, DRAIN, HALTED:
  - RUN to DRAIN on rule 7; the drain counter is loaded with DRAIN_CYCLES.
  - In DRAIN: pc_en=0, iren=0, en[0]=0, flush[1]=1. Rules 2 and 3 still apply.
  - In DRAIN the counter decrements on each non-frozen cycle.
  - DRAIN to HALTED when the counter reaches 0; DRAIN to RUN on br_taken.
  - HALTED is left only by RST.
- stall_cnt increments when hz_stall=1 and saturates at all-ones.

## Timing
- Outputs are combinational from inputs and current state, with zero added latency. All state is registered.
- Reset values: state=RUN, pend=0, shadows invalid, stall_cnt=0, halt=0.
  - The remaining outputs follow the combinational rules. With no hazard inputs and ihit=1: en=4'hF, flush=0, pc_en=1, iren=1.
- RST asserted mid-DRAIN or in HALTED returns to RUN on the next edge.
- Load-use with LOAD_LAT=1: the dependent is held in ID for exactly 1 cycle, with a bubble inserted into ID/EX.
- Freeze cycles stretch all counters without changing them.
- A write to register 0 never creates a pending entry.

## Test plan
- Load r5, then add r6,r5,r1 back to back with LOAD_LAT=1 → hz_stall=1 for 1 cycle, flush=4'b0010, pc_en=0; stall_cnt goes to 1.
- Same sequence, but dhit=0 for 3 cycles during the stall cycle → en=0 for 3 cycles, then exactly 1 stall cycle; stall_cnt=1.
- ALU_LAT=2, add r3 followed by sub r4,r3,r3 → 2 stall cycles; with a dst of r0 instead → 0 stall cycles.
- Load r7 in EX and br_taken in MEM in the same cycle → flush=4'b0111 and pend[7]=0 next cycle; a following use of r7 does not stall.
- id_halt with DRAIN_CYCLES=3 → iren=0 at once, halt=1 on the 4th edge; a br_taken 1 cycle after halt instead returns to RUN with iren=1.
- Force hz_stall with CNT_W=4 for 20 cycles → stall_cnt saturates at 15. RST then clears it to 0 and halt to 0.
